// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared types and defaults for the PWM input-capture block.
//   - cap_state_e      : per-channel capture FSM states
//   - DefaultChannels  : default number of capture channels
//   - DefaultWidth     : default width of the tick counters and result registers
package pwm_capture_pkg;

   localparam int unsigned DefaultChannels = 3;
   localparam int unsigned DefaultWidth    = 32;

   typedef enum logic [1:0] {
      StIdle,
      StWaitRise,
      StHigh,
      StLow
   } cap_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control and result bundle of pwm_capture.
//   enable_i    [CHANNELS]        per-channel capture enable
//   prescaler_i [32]              shared tick divider (tick every prescaler_i+1 clk)
//   pwm_i       [CHANNELS]        asynchronous PWM inputs
//   period_o    [CHANNELS][WIDTH] last measured period in ticks
//   high_o      [CHANNELS][WIDTH] last measured high time in ticks
//   valid_o     [CHANNELS]        one-cycle strobe when results update
//   ovf_o       [CHANNELS]        reported cycle overflowed the counter (with valid_o)
// Modports: master drives the inputs (wrapper / bench), slave is the capture block.
interface pwm_capture_if import pwm_capture_pkg::*; #(
   parameter int unsigned CHANNELS = DefaultChannels,
   parameter int unsigned WIDTH    = DefaultWidth
) ();

   logic [CHANNELS-1:0]            enable_i;
   logic [31:0]                    prescaler_i;
   logic [CHANNELS-1:0]            pwm_i;
   logic [CHANNELS-1:0][WIDTH-1:0] period_o;
   logic [CHANNELS-1:0][WIDTH-1:0] high_o;
   logic [CHANNELS-1:0]            valid_o;
   logic [CHANNELS-1:0]            ovf_o;

   modport master (
      output enable_i, prescaler_i, pwm_i,
      input  period_o, high_o, valid_o, ovf_o
   );

   modport slave (
      input  enable_i, prescaler_i, pwm_i,
      output period_o, high_o, valid_o, ovf_o
   );

endinterface

// File: rtl/pwm_capture_ch.sv
// pwm_capture_ch: one PWM capture channel.
// Synchronizes pwm_i, optionally glitch-filters it (PWM_CAPTURE_GLITCH_FILTER_EN),
// detects edges and measures period (rise to rise) and high time in ticks.
//   clk, rst   : clock, asynchronous active-high reset
//   tick_i     : shared prescaler tick
//   enable_i   : capture enable; low forces the FSM to idle
//   pwm_i      : asynchronous PWM input
//   period_o   : last period in ticks (saturating)
//   high_o     : last high time in ticks (saturating)
//   valid_o    : one-cycle strobe when period_o/high_o update
//   ovf_o      : reported cycle overflowed the counter
module pwm_capture_ch import pwm_capture_pkg::*; #(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_i,
   input  logic             enable_i,
   input  logic             pwm_i,
   output logic [WIDTH-1:0] period_o,
   output logic [WIDTH-1:0] high_o,
   output logic             valid_o,
   output logic             ovf_o
);

   localparam logic [WIDTH-1:0] CntMax = '1;

   // Input path
   logic [1:0] sync_q;
   logic       level_d;
   logic       cur_q;
   logic       prev_q;
   logic       rise;
   logic       fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], pwm_i};
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   // Synchronizer output plus two history samples form the 3-sample window;
   // the level only moves when the whole window agrees.
   logic [1:0] hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
      end else begin
         hist_q <= {hist_q[0], sync_q[1]};
      end
   end

   always_comb begin
      level_d = cur_q;
      if (sync_q[1] && (&hist_q)) begin
         level_d = 1'b1;
      end else if (!sync_q[1] && !(|hist_q)) begin
         level_d = 1'b0;
      end
   end
`else
   assign level_d = sync_q[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         cur_q  <= level_d;
         prev_q <= cur_q;
      end
   end

   assign rise = cur_q & ~prev_q;
   assign fall = ~cur_q & prev_q;

   // Measurement state
   cap_state_e       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] high_lat_q, high_lat_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             ovf_rep_q, ovf_rep_d;

   logic             at_max;
   logic             wrap;
   logic [WIDTH-1:0] cnt_inc;

   // Saturating count including the current tick; wrap marks a tick lost to saturation.
   assign at_max  = (cnt_q == CntMax);
   assign wrap    = at_max & tick_i;
   assign cnt_inc = at_max ? cnt_q : cnt_q + {{(WIDTH-1){1'b0}}, tick_i};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      high_lat_d = high_lat_q;
      period_d   = period_q;
      high_d     = high_q;
      valid_d    = 1'b0;
      ovf_rep_d  = 1'b0;

      if (!enable_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StWaitRise;
               cnt_d   = '0;
            end
            StWaitRise: begin
               if (rise) begin
                  cnt_d   = '0;
                  state_d = StHigh;
               end
            end
            StHigh: begin
               if (rise) begin
                  // Missed fall: the whole cycle counts as high.
                  period_d  = cnt_inc;
                  high_d    = cnt_inc;
                  valid_d   = 1'b1;
                  ovf_rep_d = ovf_q | wrap;
                  cnt_d     = '0;
                  ovf_d     = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | wrap;
                  if (fall) begin
                     high_lat_d = cnt_inc;
                     state_d    = StLow;
                  end
               end
            end
            StLow: begin
               if (rise) begin
                  period_d  = cnt_inc;
                  high_d    = high_lat_q;
                  valid_d   = 1'b1;
                  ovf_rep_d = ovf_q | wrap;
                  cnt_d     = '0;
                  ovf_d     = 1'b0;
                  state_d   = StHigh;
               end else begin
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | wrap;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         high_lat_q <= '0;
         period_q   <= '0;
         high_q     <= '0;
         valid_q    <= 1'b0;
         ovf_rep_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         high_lat_q <= high_lat_d;
         period_q   <= period_d;
         high_q     <= high_d;
         valid_q    <= valid_d;
         ovf_rep_q  <= ovf_rep_d;
      end
   end

   assign period_o = period_q;
   assign high_o   = high_q;
   assign valid_o  = valid_q;
   assign ovf_o    = ovf_rep_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM input capture.
// Holds the shared tick prescaler and CHANNELS independent pwm_capture_ch instances.
// Optional glitch filter per channel: define PWM_CAPTURE_GLITCH_FILTER_EN.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : pwm_capture_if.slave (enable_i, prescaler_i, pwm_i in;
//          period_o, high_o, valid_o, ovf_o out)
module pwm_capture import pwm_capture_pkg::*; #(
   parameter int unsigned CHANNELS = DefaultChannels,
   parameter int unsigned WIDTH    = DefaultWidth
) (
   input logic          clk,
   input logic          rst,
   pwm_capture_if.slave bus
);

   // Prescaler: >= compare so a lowered prescaler_i ends the count at once.
   logic [31:0] pre_cnt_q, pre_cnt_d;
   logic        tick;

   assign tick = (pre_cnt_q >= bus.prescaler_i);

   always_comb begin
      pre_cnt_d = tick ? 32'd0 : pre_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

   logic [CHANNELS-1:0][WIDTH-1:0] period;
   logic [CHANNELS-1:0][WIDTH-1:0] high;
   logic [CHANNELS-1:0]            valid;
   logic [CHANNELS-1:0]            ovf;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pwm_capture_ch #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick_i   (tick),
         .enable_i (bus.enable_i[c]),
         .pwm_i    (bus.pwm_i[c]),
         .period_o (period[c]),
         .high_o   (high[c]),
         .valid_o  (valid[c]),
         .ovf_o    (ovf[c])
      );
   end

   assign bus.period_o = period;
   assign bus.high_o   = high;
   assign bus.valid_o  = valid;
   assign bus.ovf_o    = ovf;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized scoreboard bench for pwm_capture (3 channels, 8-bit counters).
// The driver generates per-channel waveforms; a reference model derives each expected
// report from edge times and the prescaler tick pattern; a monitor checks valid_o/data.
module tb_pwm_capture;
   import pwm_capture_pkg::*;

   localparam int CH   = 3;
   localparam int W    = 8;
   localparam int LAT  = 3;             // sample edge to FSM processing edge
   localparam int MAXV = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pwm_capture_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

   pwm_capture #(
      .CHANNELS (CH),
      .WIDTH    (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int due;
      int ch;
      int period;
      int high;
      bit ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   edge_n  = 0;   // index of the next posedge since reset release

   always @(posedge clk) begin
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   // Driver / model state
   int  q_pre = 1;
   bit  frozen = 1'b0;
   bit  lvl[CH];
   int  rem[CH];
   bit  rnd[CH];
   int  hi_len[CH];
   int  lo_len[CH];
   int  seg0[$];
   bit  en_m[CH];
   int  last_rise[CH];
   int  last_fall[CH];
   int  last_per[CH];

   // Ticks occur at edges n with (n+1) % q_pre == 0; count those in (lo, hi].
   function automatic int ticks(int lo, int hi);
      return (hi + 1) / q_pre - (lo + 1) / q_pre;
   endfunction

   function automatic int sat(int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic model_level(int c, bit nl, int k);
      int per;
      int hi;
      exp_t e;
      if (nl && !lvl[c]) begin
         if (en_m[c]) begin
            if (last_rise[c] >= 0) begin
               per = ticks(last_rise[c] + LAT, k + LAT);
               hi  = (last_fall[c] >= 0) ? ticks(last_rise[c] + LAT, last_fall[c] + LAT) : per;
               e.due    = k + LAT;
               e.ch     = c;
               e.period = sat(per);
               e.high   = sat(hi);
               e.ovf    = (per > MAXV);
               exp_q.push_back(e);
               last_per[c] = sat(per);
            end
            last_rise[c] = k;
            last_fall[c] = -1;
         end
      end else if (!nl && lvl[c]) begin
         if (en_m[c] && last_rise[c] >= 0) last_fall[c] = k;
      end
   endtask

   function automatic int next_len(int c, bit nl);
      if (c == 0 && seg0.size() > 0) return seg0.pop_front();
      if (rnd[c]) return int'($urandom_range(12, 1));
      return nl ? hi_len[c] : lo_len[c];
   endfunction

   task automatic step();
      bit nl;
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
         nl = lvl[c];
         if (!frozen) begin
            if (rem[c] == 0) begin
               nl     = ~lvl[c];
               rem[c] = next_len(c, nl);
            end
            rem[c] = rem[c] - 1;
         end
         model_level(c, nl, edge_n);
         lvl[c]         = nl;
         bus.pwm_i[c]   = nl;
      end
   endtask

   task automatic flush();
      frozen = 1'b1;
      repeat (8) step();
      frozen = 1'b0;
   endtask

   task automatic cfg_ch(int c, bit en, bit r, int hi, int lo, int off);
      bus.enable_i[c] = en;
      en_m[c]         = en;
      rnd[c]          = r;
      hi_len[c]       = hi;
      lo_len[c]       = lo;
      rem[c]          = off;
      lvl[c]          = 1'b0;
      last_rise[c]    = -1;
      last_fall[c]    = -1;
   endtask

   task automatic set_en(int c, bit en);
      bus.enable_i[c] = en;
      en_m[c]         = en;
      last_rise[c]    = -1;
      last_fall[c]    = -1;
   endtask

   // Asynchronous reset: outputs must clear without a clock edge.
   task automatic start_reset(int pre);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.period_o !== '0 || bus.high_o !== '0 || bus.valid_o !== '0 || bus.ovf_o !== '0) begin
         n_fail++;
         $display("FAIL reset_state: period=%h high=%h valid=%b ovf=%b, required all 0",
                  bus.period_o, bus.high_o, bus.valid_o, bus.ovf_o);
      end
      exp_q.delete();
      seg0.delete();
      bus.pwm_i       = '0;
      bus.prescaler_i = pre;
      q_pre           = pre + 1;
      for (int c = 0; c < CH; c++) last_per[c] = 0;
   endtask

   task automatic release_rst();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: pops every expectation due at the last edge and checks the DUT.
   always @(negedge clk) begin : mon
      int      last;
      bit      want[CH];
      exp_t    ex[CH];
      exp_t    e;
      if (!rst) begin
         last = edge_n - 1;
         for (int c = 0; c < CH; c++) want[c] = 1'b0;
         while (exp_q.size() > 0 && exp_q[0].due <= last) begin
            e = exp_q.pop_front();
            if (e.due < last) begin
               n_tests++;
               n_fail++;
               $display("FAIL missing_report ch%0d edge %0d: valid_o=0, required 1", e.ch, e.due);
            end else begin
               want[e.ch] = 1'b1;
               ex[e.ch]   = e;
            end
         end
         for (int c = 0; c < CH; c++) begin
            if (bus.valid_o[c] === 1'b1 || want[c]) begin
               n_tests++;
               if (!want[c]) begin
                  n_fail++;
                  $display("FAIL unexpected_valid ch%0d edge %0d: valid_o=1, required 0", c, last);
               end else if (bus.valid_o[c] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL missing_report ch%0d edge %0d: valid_o=%b, required 1",
                           c, last, bus.valid_o[c]);
               end else if (int'(bus.period_o[c]) != ex[c].period ||
                            int'(bus.high_o[c]) != ex[c].high || bus.ovf_o[c] !== ex[c].ovf) begin
                  n_fail++;
                  $display("FAIL report ch%0d edge %0d: got period=%0d high=%0d ovf=%b, required period=%0d high=%0d ovf=%b",
                           c, last, bus.period_o[c], bus.high_o[c], bus.ovf_o[c],
                           ex[c].period, ex[c].high, ex[c].ovf);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int i;

      // Basic: period 10, high 3, prescaler 0
      start_reset(0);
      cfg_ch(0, 1, 0, 3, 7, 2);
      cfg_ch(1, 0, 1, 0, 0, 0);
      cfg_ch(2, 0, 1, 0, 0, 0);
      release_rst();
      repeat (60) step();
      flush();

      // Prescaler 3: period 40 / high 12 -> 10 / 3; other channels random
      start_reset(3);
      cfg_ch(0, 1, 0, 12, 28, 5);
      cfg_ch(1, 1, 1, 0, 0, 1);
      cfg_ch(2, 1, 1, 0, 0, 3);
      release_rst();
      repeat (200) step();
      flush();

      // Overflow: 300-cycle period saturates, following 100-cycle period is clean
      start_reset(0);
      cfg_ch(0, 1, 0, 30, 70, 2);
      seg0 = '{40, 260, 30, 70};
      cfg_ch(1, 1, 1, 0, 0, 0);
      cfg_ch(2, 1, 1, 0, 0, 0);
      release_rst();
      repeat (520) step();
      flush();

      // Enable dropped mid-high, results held, re-enabled mid-low
      start_reset(0);
      cfg_ch(0, 1, 0, 10, 10, 2);
      cfg_ch(1, 0, 1, 0, 0, 0);
      cfg_ch(2, 0, 1, 0, 0, 0);
      release_rst();
      repeat (50) step();
      for (i = 0; i < 100 && !(lvl[0] && (hi_len[0] - rem[0]) >= 5); i++) step();
      if (i >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_mid_high: condition not reached in 100 cycles");
      end
      set_en(0, 1'b0);
      repeat (30) step();
      n_tests++;
      if (int'(bus.period_o[0]) != last_per[0]) begin
         n_fail++;
         $display("FAIL hold_period ch0: got %0d, required %0d", bus.period_o[0], last_per[0]);
      end
      for (i = 0; i < 100 && !(!lvl[0] && (lo_len[0] - rem[0]) >= 3); i++) step();
      if (i >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_mid_low: condition not reached in 100 cycles");
      end
      set_en(0, 1'b1);
      repeat (60) step();
      flush();

      // Coincident rising edges on all channels
      start_reset(1);
      cfg_ch(0, 1, 0, 3, 13, 4);
      cfg_ch(1, 1, 0, 7, 9, 4);
      cfg_ch(2, 1, 0, 10, 6, 4);
      release_rst();
      repeat (80) step();
      flush();

      // 2-cycle glitch in low phase is measured as a real pulse
      start_reset(0);
      cfg_ch(0, 1, 0, 5, 15, 2);
      seg0 = '{5, 15, 5, 5, 2, 8};
      cfg_ch(1, 0, 1, 0, 0, 0);
      cfg_ch(2, 0, 1, 0, 0, 0);
      release_rst();
      repeat (90) step();
      flush();

      // Random traffic, then reset mid-measurement (no partial report afterwards)
      start_reset(int'($urandom_range(3, 0)));
      cfg_ch(0, 1, 1, 0, 0, 0);
      cfg_ch(1, 1, 1, 0, 0, 2);
      cfg_ch(2, 1, 1, 0, 0, 4);
      release_rst();
      repeat (300) step();
      start_reset(int'($urandom_range(3, 0)));
      cfg_ch(0, 1, 1, 0, 0, 1);
      cfg_ch(1, 1, 1, 0, 0, 0);
      cfg_ch(2, 1, 1, 0, 0, 3);
      release_rst();
      repeat (150) step();
      flush();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
